// File: rtl/exec_unit_p.sv
// exec_unit_p -- parametrised execute stage for the NoobsCpu core.
//
// Sits between decode and writeback/fetch. On an accepted instruction
// (execute_en=1 while exec_busy=0) it evaluates ALU / flag / branch ops in one
// cycle and launches LD/ST as a ready-based data-memory request, stalling
// upstream through exec_busy until the memory answers or the wait times out.
//
// Ports:
//   clk, reset_           rising-edge clock, asynchronous active-low reset
//   execute_en            issue strobe (ignored while exec_busy=1)
//   exec_ctrl             opcode
//   reg_src0_data/1_data  operands A/B
//   imm_data              immediate
//   dst_reg               destination register select
//   dst_addr              memory address or branch target
//   next_addr             fall-through PC
//   tgt_addr              resolved next PC (registered)
//   branch_taken          one-cycle redirect pulse
//   reg_wr_data/sel/en    writeback data, register, one-cycle enable
//   flags                 {N,C,Z}, persistent
//   exec_busy             stall to upstream (combinational from state)
//   d_mem_*               data-memory request/response
//   mem_err               sticky memory-timeout error
module exec_unit_p #(
   parameter int DW     = 8,
   parameter int AW     = 12,
   parameter int RSW    = 3,
   parameter int MEM_TO = 16
) (
   input  logic           clk,
   input  logic           reset_,
   input  logic           execute_en,
   input  logic [3:0]     exec_ctrl,
   input  logic [DW-1:0]  reg_src0_data,
   input  logic [DW-1:0]  reg_src1_data,
   input  logic [DW-1:0]  imm_data,
   input  logic [RSW-1:0] dst_reg,
   input  logic [AW-1:0]  dst_addr,
   input  logic [AW-1:0]  next_addr,
   output logic [AW-1:0]  tgt_addr,
   output logic           branch_taken,
   output logic [DW-1:0]  reg_wr_data,
   output logic [RSW-1:0] reg_wr_sel,
   output logic           reg_wr_en,
   output logic [2:0]     flags,
   output logic           exec_busy,
   output logic [AW-1:0]  d_mem_addr,
   output logic [DW-1:0]  d_mem_wdata,
   input  logic [DW-1:0]  d_mem_rdata,
   output logic           d_mem_en,
   output logic           d_mem_rd,
   output logic           d_mem_wr,
   input  logic           d_mem_ready,
   output logic           mem_err
);

   localparam int CW = $clog2(MEM_TO + 1);

   typedef enum logic {IDLE, REQ} state_t;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,
      OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_ADDI = 4'd6, OP_MOVI = 4'd7,
      OP_LD   = 4'd8,  OP_ST  = 4'd9,  OP_JMP = 4'd10, OP_JZ  = 4'd11,
      OP_JC   = 4'd12, OP_SHL = 4'd13, OP_SHR = 4'd14, OP_CMP = 4'd15
   } op_t;

   state_t        state;
   logic [CW-1:0] to_cnt;

   op_t           op;
   logic [DW:0]   add_ab, add_ai, sub_ab;
   logic [DW-1:0] alu_res;
   logic          alu_c;
   logic          alu_wr;
   logic          alu_fl;
   logic          taken;
   logic          is_mem;

   assign exec_busy = (state == REQ);

   always_comb begin
      op      = op_t'(exec_ctrl);
      add_ab  = {1'b0, reg_src0_data} + {1'b0, reg_src1_data};
      add_ai  = {1'b0, reg_src0_data} + {1'b0, imm_data};
      // Top bit of the widened difference is the unsigned borrow (A<B).
      sub_ab  = {1'b0, reg_src0_data} - {1'b0, reg_src1_data};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_wr  = 1'b0;
      alu_fl  = 1'b0;
      case (op)
         OP_ADD:  begin {alu_c, alu_res} = add_ab; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_SUB:  begin {alu_c, alu_res} = sub_ab; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_AND:  begin alu_res = reg_src0_data & reg_src1_data; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_OR:   begin alu_res = reg_src0_data | reg_src1_data; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_XOR:  begin alu_res = reg_src0_data ^ reg_src1_data; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_ADDI: begin {alu_c, alu_res} = add_ai; alu_wr = 1'b1; alu_fl = 1'b1; end
         OP_MOVI: begin alu_res = imm_data; alu_wr = 1'b1; end
         OP_SHL:  begin
            alu_res = {reg_src0_data[DW-2:0], 1'b0};
            alu_c   = reg_src0_data[DW-1];
            alu_wr  = 1'b1;
            alu_fl  = 1'b1;
         end
         OP_SHR:  begin
            alu_res = {1'b0, reg_src0_data[DW-1:1]};
            alu_c   = reg_src0_data[0];
            alu_wr  = 1'b1;
            alu_fl  = 1'b1;
         end
         OP_CMP:  begin {alu_c, alu_res} = sub_ab; alu_fl = 1'b1; end
         default: ;
      endcase
      // Conditional branches see the flag register as left by the previous
      // instruction, which has already been written at its own accept edge.
      taken  = (op == OP_JMP) || ((op == OP_JZ) && flags[0]) || ((op == OP_JC) && flags[1]);
      is_mem = (op == OP_LD) || (op == OP_ST);
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state        <= IDLE;
         to_cnt       <= '0;
         tgt_addr     <= '0;
         branch_taken <= 1'b0;
         reg_wr_data  <= '0;
         reg_wr_sel   <= '0;
         reg_wr_en    <= 1'b0;
         flags        <= '0;
         d_mem_addr   <= '0;
         d_mem_wdata  <= '0;
         d_mem_en     <= 1'b0;
         d_mem_rd     <= 1'b0;
         d_mem_wr     <= 1'b0;
         mem_err      <= 1'b0;
      end else begin
         reg_wr_en    <= 1'b0;
         branch_taken <= 1'b0;
         case (state)
            IDLE: begin
               if (execute_en) begin
                  tgt_addr     <= taken ? dst_addr : next_addr;
                  branch_taken <= taken;
                  reg_wr_sel   <= dst_reg;
                  if (alu_wr) begin
                     reg_wr_en   <= 1'b1;
                     reg_wr_data <= alu_res;
                  end
                  if (alu_fl)
                     flags <= {alu_res[DW-1], alu_c, (alu_res == '0)};
                  if (is_mem) begin
                     state       <= REQ;
                     to_cnt      <= '0;
                     d_mem_en    <= 1'b1;
                     d_mem_rd    <= (op == OP_LD);
                     d_mem_wr    <= (op == OP_ST);
                     d_mem_addr  <= dst_addr;
                     d_mem_wdata <= reg_src0_data;
                  end
               end
            end
            REQ: begin
               // Ready is checked first so a response on the last allowed
               // cycle completes instead of timing out.
               if (d_mem_ready) begin
                  state    <= IDLE;
                  to_cnt   <= '0;
                  d_mem_en <= 1'b0;
                  d_mem_rd <= 1'b0;
                  d_mem_wr <= 1'b0;
                  if (d_mem_rd) begin
                     reg_wr_en   <= 1'b1;
                     reg_wr_data <= d_mem_rdata;
                  end
               end else if (to_cnt == CW'(MEM_TO - 1)) begin
                  state    <= IDLE;
                  to_cnt   <= '0;
                  d_mem_en <= 1'b0;
                  d_mem_rd <= 1'b0;
                  d_mem_wr <= 1'b0;
                  mem_err  <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
